// File: rtl/lifegame_key_ctrl.sv
// lifegame_key_ctrl: decodes PS/2 make codes into Life-game controls.
// The controls are cursor moves, cell toggle, run/pause, single step, clear and speed.
// The driver's byte/state outputs are double-registered to detect new presses.
// Optional feature macro: LIFEGAME_ARROW_KEYS_EN adds E0-prefixed arrow-key decode.
module lifegame_key_ctrl #(
   parameter int GRID_W = 32,
   parameter int GRID_H = 32,
   parameter int XW     = 5,
   parameter int YW     = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    ps2_byte,
   input  logic          ps2_state,
   output logic [XW-1:0] cur_x,
   output logic [YW-1:0] cur_y,
   output logic          toggle_pulse,
   output logic          step_pulse,
   output logic          clear_pulse,
   output logic          run,
   output logic [1:0]    speed
);

`ifdef LIFEGAME_ARROW_KEYS_EN
   typedef enum logic {IDLE, PREFIX} state_t;
`else
   typedef enum logic {IDLE} state_t;
`endif

   state_t     state;
   logic [7:0] s_byte;
   logic [7:0] p_byte;
   logic       s_state;
   logic       p_state;
   logic       key_event;
`ifdef LIFEGAME_ARROW_KEYS_EN
   logic       key_fall;
`endif

   // Cursor wrap uses explicit limit compares because the grid need not be a power of two.
   function automatic logic [XW-1:0] x_dec(input logic [XW-1:0] x);
      return (x == '0) ? XW'(GRID_W - 1) : x - XW'(1);
   endfunction

   function automatic logic [XW-1:0] x_inc(input logic [XW-1:0] x);
      return (x == XW'(GRID_W - 1)) ? '0 : x + XW'(1);
   endfunction

   function automatic logic [YW-1:0] y_dec(input logic [YW-1:0] y);
      return (y == '0) ? YW'(GRID_H - 1) : y - YW'(1);
   endfunction

   function automatic logic [YW-1:0] y_inc(input logic [YW-1:0] y);
      return (y == YW'(GRID_H - 1)) ? '0 : y + YW'(1);
   endfunction

   // Two-stage capture of the driver outputs for edge/change detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_byte  <= 8'h00;
         s_state <= 1'b0;
         p_byte  <= 8'h00;
         p_state <= 1'b0;
      end else begin
         s_byte  <= ps2_byte;
         s_state <= ps2_state;
         p_byte  <= s_byte;
         p_state <= s_state;
      end
   end

   // A new key is a rising state or a changed byte while held; a held repeat of the same code is no event.
   always_comb begin
      key_event = s_state & (~p_state | (s_byte != p_byte));
   end

`ifdef LIFEGAME_ARROW_KEYS_EN
   // Key release seen at the sampler; used to abandon a dangling E0 prefix.
   always_comb begin
      key_fall = p_state & ~s_state;
   end
`endif

   // Command FSM with registered outputs; pulses default low so each lasts one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         cur_x        <= '0;
         cur_y        <= '0;
         toggle_pulse <= 1'b0;
         step_pulse   <= 1'b0;
         clear_pulse  <= 1'b0;
         run          <= 1'b0;
         speed        <= 2'd0;
      end else begin
         toggle_pulse <= 1'b0;
         step_pulse   <= 1'b0;
         clear_pulse  <= 1'b0;
         case (state)
            IDLE: begin
               if (key_event) begin
                  case (s_byte)
                     8'h1D: cur_y <= y_dec(cur_y);
                     8'h1B: cur_y <= y_inc(cur_y);
                     8'h1C: cur_x <= x_dec(cur_x);
                     8'h23: cur_x <= x_inc(cur_x);
                     8'h29: toggle_pulse <= ~run;
                     8'h5A: run <= ~run;
                     8'h31: step_pulse <= ~run;
                     8'h21: clear_pulse <= ~run;
                     8'h55: if (speed != 2'd3) speed <= speed + 2'd1;
                     8'h4E: if (speed != 2'd0) speed <= speed - 2'd1;
`ifdef LIFEGAME_ARROW_KEYS_EN
                     8'hE0: state <= PREFIX;
`endif
                     default: ;
                  endcase
               end
            end
`ifdef LIFEGAME_ARROW_KEYS_EN
            PREFIX: begin
               if (key_fall) begin
                  state <= IDLE;
               end else if (key_event) begin
                  state <= IDLE;
                  case (s_byte)
                     8'h75: cur_y <= y_dec(cur_y);
                     8'h72: cur_y <= y_inc(cur_y);
                     8'h6B: cur_x <= x_dec(cur_x);
                     8'h74: cur_x <= x_inc(cur_x);
                     default: ;
                  endcase
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule
